mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Parametrised memory-mapped bus controller between the datapath's load/store port and `NUM_SLV` memory or I/O slaves, such as data memory and image RAM. It decodes each access with per-slave base/mask pairs and issues a registered strobe to the selected slave. Reads wait a per-slave latency, and narrow read data is zero-extended. The CPU is stalled until the access completes. Unmapped accesses are reported.

## Interface
Parameters:
- `DATA_W`, 22: CPU data width.
- `ADDR_W`, 22: CPU address width.
- `NUM_SLV`, 2: number of slaves, 1..8.
- `SLV_BASE`, {22'h080000, 22'h000000}: packed `NUM_SLV*ADDR_W` base addresses; slave i occupies slice i.
- `SLV_MASK`, {22'h380000, 22'h3F0000}: packed decode masks.
- `SLV_LAT`, {4'd1, 4'd0}: packed read latency per slave, 0..15.
- `SLV_DW`, {5'd8, 5'd22}: packed valid read-data width per slave, 1..`DATA_W`.

Ports (clock and reset first):
- `clk`, in, 1: the block's single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `cpu_req`, in, 1: access request; held high by the CPU while `cpu_stall` is high.
- `cpu_we`, in, 1: 1 = write, 0 = read.
- `cpu_adr`, in, `ADDR_W`: access address.
- `cpu_wdata`, in, `DATA_W`: write data.
- `cpu_rdata`, out, `DATA_W`: registered read data.
- `cpu_stall`, out, 1: freezes the CPU.
- `cpu_err`, out, 1: one-cycle pulse on an unmapped access.
- `err_cnt`, out, 8: saturating count of unmapped accesses.
- `slv_sel`, out, `NUM_SLV`: one-hot registered select.
- `slv_we`, out, 1: registered write enable, qualified by `slv_sel`.
- `slv_adr`, out, `ADDR_W`: registered offset, `cpu_adr & ~SLV_MASK[i]`.
- `slv_wdata`, out, `DATA_W`: registered write data.
- `slv_rdata`, in, `NUM_SLV*DATA_W`: packed slave read data.

## Operation
Decode:
- Slave i hits when `(cpu_adr & SLV_MASK[i]) == SLV_BASE[i]`.
- When several slaves hit, the lowest index wins.
- When no slave hits, the access is unmapped.

FSM states are IDLE, ISSUE, WAIT, DONE. Transitions:
- IDLE: with `cpu_req` high and a hit, latch the index, address offset, write data and `we`, then go to ISSUE. With `cpu_req` high and no hit, go to DONE with the error flag set. With `cpu_req` low, stay in IDLE.
- ISSUE: `slv_sel[i]` is high for exactly this cycle, and `slv_we` equals the latched `we`.
  - Write: go to DONE.
  - Read with LAT=0: capture `slv_rdata` slice i at the end of this cycle, then go to DONE.
  - Read with LAT>0: load the counter with LAT-1, then go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, capture `slv_rdata` slice i and go to DONE.
- DONE: `cpu_stall` is low and `cpu_rdata` is valid; the next state is IDLE.

Outputs and data rules:
- `cpu_stall` = `cpu_req` && state != DONE && !(state == IDLE && !`cpu_req`). Equivalently, it is high from the request cycle until DONE.
- Read capture: `cpu_rdata` = slice i with bits at and above `SLV_DW[i]` forced to 0.
- Unmapped read: `cpu_rdata` = 0.
- Writes and unmapped accesses leave `cpu_rdata` unchanged, except that an unmapped read loads 0.
- On an unmapped access, `cpu_err` pulses in DONE and `err_cnt` increments, saturating at 255.
- If `cpu_req` drops mid-transaction (illegal), the access still completes and DONE lasts one cycle.
- Slave outputs (`slv_adr`, `slv_wdata`, `slv_we`) hold their values outside ISSUE. `slv_sel` is 0 outside ISSUE.
- Slave read data is expected valid LAT cycles after its ISSUE cycle.

## Timing
- Request sampled at edge 0 (IDLE).
- Write: ISSUE in cycle 1, DONE in cycle 2. Stall is high for 2 cycles.
- Read: ISSUE in cycle 1, WAIT for LAT cycles, capture at the end of cycle 1+LAT, DONE in cycle 2+LAT. Stall is high for 2+LAT cycles.
- Unmapped access: DONE in cycle 1. Stall is high for 1 cycle.
- Back-to-back: a request held high after DONE is accepted in the following IDLE cycle, so there is 1 idle cycle between accesses.

Reset values, applied asynchronously whenever `reset` is low, including mid-transaction:
- FSM returns to IDLE and any access in flight is aborted.
- `slv_sel` = 0, `slv_we` = 0, `slv_adr` = 0, `slv_wdata` = 0.
- `cpu_rdata` = 0, `cpu_err` = 0, `err_cnt` = 0, counter = 0.
- `cpu_stall` follows `cpu_req` combinationally from IDLE.

## Test plan
- Write `cpu_adr` = 22'h000010, `cpu_wdata` = 22'h12345: `slv_sel` = 01 for one cycle with `slv_adr` = 22'h000010, `slv_we` = 1. `cpu_stall` is high for 2 cycles.
- Read from slave 0 (LAT=0) at 22'h000010 with slice 0 = 22'h12345: `cpu_rdata` = 22'h12345 in cycle 2; stall is high for 2 cycles.
- Read from slave 1 (LAT=1) at 22'h080005 with slice 1 = 22'h3FFFA5: `slv_adr` = 22'h000005; `cpu_rdata` = 22'h0000A5 (zero-extended from 8 bits) in cycle 3.
- Access 22'h200000 (unmapped) 257 times: each access gives a one-cycle `cpu_err` pulse, `cpu_rdata` = 0 for reads, no `slv_sel` activity, and `err_cnt` saturates at 255.
- Assert `reset` low during WAIT of a slave-1 read: all outputs reach their reset values without waiting for a clock edge. After reset is released, a new read completes normally.
- Overlap check: set slave 1 base/mask to also match 22'h000010. A read there selects slave 0 only.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Memory-mapped bus controller: decodes CPU load/store accesses onto NUM_SLV slaves
// via base/mask pairs, waits a per-slave read latency, and stalls the CPU until done.
module mem_bus_ctrl #(
    parameter int unsigned DATA_W  = 22,
    parameter int unsigned ADDR_W  = 22,
    parameter int unsigned NUM_SLV = 2,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {22'h080000, 22'h000000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {22'h380000, 22'h3F0000},
    parameter logic [NUM_SLV*4-1:0]      SLV_LAT  = {4'd1, 4'd0},
    parameter logic [NUM_SLV*$clog2(DATA_W+1)-1:0] SLV_DW = {5'd8, 5'd22}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [ADDR_W-1:0]         cpu_adr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_stall,
    output logic                      cpu_err,
    output logic [7:0]                err_cnt,
    output logic [NUM_SLV-1:0]        slv_sel,
    output logic                      slv_we,
    output logic [ADDR_W-1:0]         slv_adr,
    output logic [DATA_W-1:0]         slv_wdata,
    input  logic [NUM_SLV*DATA_W-1:0] slv_rdata
);

    localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned DW_W  = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state, state_nxt;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [ADDR_W-1:0]  hit_off;
    logic [NUM_SLV-1:0] sel_dec;
    logic [IDX_W-1:0]   idx_q;
    logic [3:0]         cnt;
    logic [3:0]         lat_sel;
    logic [DW_W-1:0]    dw_sel;
    logic [DATA_W-1:0]  rd_slice;
    logic [DATA_W-1:0]  rd_masked;

    // Scan from the top index down so the lowest matching slave wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = NUM_SLV; i > 0; i--) begin
            if ((cpu_adr & SLV_MASK[(i-1)*ADDR_W +: ADDR_W]) == SLV_BASE[(i-1)*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i - 1);
            end
        end
    end

    always_comb begin
        hit_off          = cpu_adr & ~SLV_MASK[hit_idx*ADDR_W +: ADDR_W];
        sel_dec          = '0;
        sel_dec[hit_idx] = 1'b1;
    end

    always_comb begin
        lat_sel  = SLV_LAT[idx_q*4 +: 4];
        dw_sel   = SLV_DW[idx_q*DW_W +: DW_W];
        rd_slice = slv_rdata[idx_q*DATA_W +: DATA_W];
        rd_masked = '0;
        for (int unsigned b = 0; b < DATA_W; b++) begin
            rd_masked[b] = rd_slice[b] & (b < 32'(dw_sel));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_nxt = hit ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (slv_we || (lat_sel == 4'd0)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_stall = cpu_req && (state != DONE);
    end

    // slv_we doubles as the latched write flag for the access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q     <= '0;
            cnt       <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            err_cnt   <= '0;
            slv_sel   <= '0;
            slv_we    <= 1'b0;
            slv_adr   <= '0;
            slv_wdata <= '0;
        end else begin
            cpu_err <= 1'b0;
            slv_sel <= '0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (hit) begin
                            idx_q     <= hit_idx;
                            slv_sel   <= sel_dec;
                            slv_we    <= cpu_we;
                            slv_adr   <= hit_off;
                            slv_wdata <= cpu_wdata;
                        end else begin
                            cpu_err <= 1'b1;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                            if (!cpu_we) begin
                                cpu_rdata <= '0;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (!slv_we) begin
                        if (lat_sel == 4'd0) begin
                            cpu_rdata <= rd_masked;
                        end else begin
                            cnt <= lat_sel - 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        cpu_rdata <= rd_masked;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: the driver queues expected CPU completions and
// slave strobes; monitors pop and compare whenever the DUT presents them.
module tb_mem_bus_ctrl;

    localparam logic [21:0] JUNK = 22'h155555;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [21:0] cpu_adr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, cpu_err;
    logic [7:0]  err_cnt;
    logic [1:0]  slv_sel;
    logic        slv_we;
    logic [21:0] slv_adr, slv_wdata;
    logic [43:0] slv_rdata;

    logic        req2, we2;
    logic [21:0] adr2, wd2, rdata2;
    logic        stall2, err2;
    logic [7:0]  ecnt2;
    logic [1:0]  sel2;
    logic        swe2;
    logic [21:0] sadr2, swd2;
    logic [43:0] srd2;

    logic [21:0] mem0, mem1;
    logic [3:0]  age1;

    int total = 0;
    int bad   = 0;
    int mon_st = 0;

    typedef struct { logic [21:0] rd; logic err; logic [7:0] ec; int st; } cpu_exp_t;
    typedef struct { logic [1:0] sel; logic we; logic [21:0] adr; logic [21:0] wd; } slv_exp_t;
    cpu_exp_t cpu_q[$];
    slv_exp_t slv_q[$];

    always #5 clk = ~clk;

    mem_bus_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err), .err_cnt(err_cnt),
        .slv_sel(slv_sel), .slv_we(slv_we), .slv_adr(slv_adr), .slv_wdata(slv_wdata),
        .slv_rdata(slv_rdata)
    );

    mem_bus_ctrl #(
        .SLV_BASE({22'h000000, 22'h000000}),
        .SLV_MASK({22'h3F0000, 22'h3F0000})
    ) dut2 (
        .clk(clk), .reset(reset),
        .cpu_req(req2), .cpu_we(we2), .cpu_adr(adr2), .cpu_wdata(wd2),
        .cpu_rdata(rdata2), .cpu_stall(stall2), .cpu_err(err2), .err_cnt(ecnt2),
        .slv_sel(sel2), .slv_we(swe2), .slv_adr(sadr2), .slv_wdata(swd2),
        .slv_rdata(srd2)
    );

    assign srd2 = {22'h3F00F0, 22'h0ABCD};

    // Slave models drive valid data only in the cycle LAT cycles after their strobe.
    always @(posedge clk or negedge reset) begin
        if (!reset) age1 <= 4'd0;
        else if (slv_sel[1]) age1 <= 4'd1;
        else if (age1 != 4'd0 && age1 != 4'd15) age1 <= age1 + 4'd1;
    end
    assign slv_rdata[21:0]  = slv_sel[0] ? mem0 : JUNK;
    assign slv_rdata[43:22] = (age1 == 4'd1) ? mem1 : JUNK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cpu_exp_t e;
        if (!reset) begin
            mon_st = 0;
        end else if (cpu_req) begin
            if (cpu_stall) begin
                mon_st++;
            end else if (cpu_q.size() == 0) begin
                chk("cpu_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = cpu_q.pop_front();
                chk("cpu_rdata", 32'(cpu_rdata), 32'(e.rd));
                chk("cpu_err",   32'(cpu_err),   32'(e.err));
                chk("err_cnt",   32'(err_cnt),   32'(e.ec));
                chk("stall_cycles", 32'(mon_st), 32'(e.st));
                mon_st = 0;
            end
        end
        if (!(reset && cpu_req && !cpu_stall)) begin
            chk("cpu_err_stray", 32'(cpu_err), 32'd0);
        end
    end

    always @(negedge clk) begin
        slv_exp_t s;
        if (slv_sel != 2'b00) begin
            if (slv_q.size() == 0) begin
                chk("slv_sel_unexpected", 32'(slv_sel), 32'd0);
            end else begin
                s = slv_q.pop_front();
                chk("slv_sel",   32'(slv_sel),   32'(s.sel));
                chk("slv_we",    32'(slv_we),    32'(s.we));
                chk("slv_adr",   32'(slv_adr),   32'(s.adr));
                chk("slv_wdata", 32'(slv_wdata), 32'(s.wd));
            end
        end
    end

    // Called just after a rising edge with cpu_req low; returns likewise.
    task automatic access(input logic we, input logic [21:0] adr, input logic [21:0] wd,
                          input logic [21:0] exp_rd, input logic exp_err, input logic [7:0] exp_ec,
                          input int exp_st, input logic [1:0] exp_sel, input logic [21:0] exp_off);
        int n;
        cpu_q.push_back('{rd: exp_rd, err: exp_err, ec: exp_ec, st: exp_st});
        if (exp_sel != 2'b00) slv_q.push_back('{sel: exp_sel, we: we, adr: exp_off, wd: wd});
        cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_stall && n < 40);
        if (cpu_stall) chk("access_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 cpu_req = 1'b0;
    endtask

    initial begin
        logic [21:0] model_rd;
        int ec;
        int n;
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        req2 = 1'b0; we2 = 1'b0; adr2 = '0; wd2 = '0;
        mem0 = 22'h12345; mem1 = 22'h3FFFA5;
        #2;
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_err",   32'(cpu_err),   32'd0);
        chk("rst_ecnt",  32'(err_cnt),   32'd0);
        chk("rst_sel",   32'(slv_sel),   32'd0);
        chk("rst_adr",   32'(slv_adr),   32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        access(1'b1, 22'h000010, 22'h12345, 22'h0,     1'b0, 8'd0, 2, 2'b01, 22'h000010);
        access(1'b0, 22'h000010, 22'h00AAA, 22'h12345, 1'b0, 8'd0, 2, 2'b01, 22'h000010);
        access(1'b0, 22'h080005, 22'h0BBBB, 22'h0000A5, 1'b0, 8'd0, 3, 2'b10, 22'h000005);
        access(1'b1, 22'h0C1234, 22'h2AAAA, 22'h0000A5, 1'b0, 8'd0, 2, 2'b10, 22'h041234);

        // Reset asserted in the WAIT cycle of a slave-1 read, between clock edges.
        slv_q.push_back('{sel: 2'b10, we: 1'b0, adr: 22'h000005, wd: 22'h01111});
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 22'h080005; cpu_wdata = 22'h01111;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_rdata", 32'(cpu_rdata), 32'd0);
        chk("arst_sel",   32'(slv_sel),   32'd0);
        chk("arst_we",    32'(slv_we),    32'd0);
        chk("arst_adr",   32'(slv_adr),   32'd0);
        chk("arst_wdata", 32'(slv_wdata), 32'd0);
        chk("arst_err",   32'(cpu_err),   32'd0);
        chk("arst_stall", 32'(cpu_stall), 32'd1);
        cpu_req = 1'b0;
        #1 chk("arst_stall_low", 32'(cpu_stall), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        mem1 = 22'h2345CC; mem0 = 22'h3ABCDE;
        access(1'b0, 22'h0FFFFF, 22'h00001, 22'h0000CC, 1'b0, 8'd0, 3, 2'b10, 22'h07FFFF);
        access(1'b0, 22'h00FFFF, 22'h00002, 22'h3ABCDE, 1'b0, 8'd0, 2, 2'b01, 22'h00FFFF);

        model_rd = 22'h3ABCDE;
        for (int i = 0; i < 257; i++) begin
            ec = (i + 1 > 255) ? 255 : i + 1;
            if (i % 2 == 1) model_rd = 22'h0;
            access((i % 2 == 0), 22'h200000 | 22'(i), 22'h3FFFFF, model_rd, 1'b1, 8'(ec), 1, 2'b00, 22'h0);
        end
        access(1'b0, 22'h010000, 22'h00003, 22'h0, 1'b1, 8'd255, 1, 2'b00, 22'h0);
        access(1'b1, 22'h00FFFF, 22'h3FFFFF, 22'h0, 1'b0, 8'd255, 2, 2'b01, 22'h00FFFF);

        // Overlapping decode: both slaves match, slave 0 must win.
        req2 = 1'b1; we2 = 1'b0; adr2 = 22'h000010; wd2 = 22'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sel2 == 2'b00 && n < 10);
        chk("ovl_sel", 32'(sel2),  32'd1);
        chk("ovl_adr", 32'(sadr2), 32'h10);
        n = 0;
        while (stall2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ovl_stall_done", 32'(stall2), 32'd0);
        chk("ovl_rdata", 32'(rdata2), 32'h0ABCD);
        @(posedge clk);
        #1 req2 = 1'b0;

        repeat (3) @(negedge clk);
        chk("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        chk("slv_q_empty", 32'(slv_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
